cpu_bus_sequencer: RTL and testbench

//  Multi-byte memory access sequencer between the CPU stage FSM and the 8-bit memory bus.

---
 rtl/cpu_bus_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_cpu_bus_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_sequencer.sv
// cpu_bus_sequencer: multi-byte little-endian access sequencer between the CPU
// stage FSM and an 8-bit memory bus. One request in flight at a time; each byte
// holds the bus for CYCLES_PER_ACCESS clocks and reads are sampled READ_LATENCY
// edges after the address is driven.
//
// Request handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE and not under reset.
// req_* inputs are captured at accept and ignored until the next accept.
// Completion is a single-clock rsp_valid pulse. rsp_rdata holds its value until
// the next accept.
module cpu_bus_sequencer #(
    parameter int MAX_BYTES         = 2,
    parameter int CYCLES_PER_ACCESS = 4,
    parameter int READ_LATENCY      = 1,
    parameter int ADDR_W            = 16,
    localparam int LEN_W            = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic                   req_sext,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [LEN_W-1:0]       req_len,
    input  logic [8*MAX_BYTES-1:0] req_wdata,
    output logic                   rsp_valid,
    output logic [8*MAX_BYTES-1:0] rsp_rdata,
    output logic                   busy,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [7:0]             mem_data_write,
    output logic                   mem_do_write,
    input  logic [7:0]             mem_data_read
);

    localparam int DW     = 8 * MAX_BYTES;
    localparam int BYTE_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int CYC_W  = $clog2(CYCLES_PER_ACCESS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BYTE_W-1:0]  byte_q, byte_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               write_q, write_d;
    logic               sext_q, sext_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [7:0]         mem_wdata_q, mem_wdata_d;
    logic               mem_do_write_q, mem_do_write_d;
    logic               last_byte;

    assign req_ready      = (state_q == IDLE) && !reset;
    assign busy           = !req_ready;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign mem_addr       = mem_addr_q;
    assign mem_data_write = mem_wdata_q;
    assign mem_do_write   = mem_do_write_q;

    // Next-state logic: sequences bytes, drives the bus one byte window at a time.
    always_comb begin
        state_d        = state_q;
        byte_d         = byte_q;
        cyc_d          = cyc_q;
        addr_d         = addr_q;
        len_d          = len_q;
        write_d        = write_q;
        sext_d         = sext_q;
        wdata_d        = wdata_q;
        rsp_valid_d    = 1'b0;
        rsp_rdata_d    = rsp_rdata_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_do_write_d = 1'b0;
        last_byte      = ((LEN_W'(byte_q) + LEN_W'(1)) == len_q);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d      = req_addr;
                    write_d     = req_write;
                    sext_d      = req_sext;
                    wdata_d     = req_wdata;
                    len_d       = (req_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : req_len;
                    rsp_rdata_d = '0;
                    byte_d      = '0;
                    cyc_d       = '0;
                    if (req_len == '0) begin
                        // Zero-length request completes without touching the bus.
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d    = ACCESS;
                        mem_addr_d = req_addr;
                        if (req_write) begin
                            mem_wdata_d    = req_wdata[7:0];
                            mem_do_write_d = 1'b1;
                        end
                    end
                end
            end
            ACCESS: begin
                if (!write_q && cyc_q == CYC_W'(READ_LATENCY - 1)) begin
                    rsp_rdata_d[8*int'(byte_q) +: 8] = mem_data_read;
                end
                if (cyc_q == CYC_W'(CYCLES_PER_ACCESS - 1)) begin
                    cyc_d = '0;
                    if (last_byte) begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        // Byte 0 was captured earlier in the window, so its sign bit is final here.
                        if (!write_q && sext_q && len_q == LEN_W'(1)) begin
                            for (int b = 1; b < MAX_BYTES; b++) begin
                                rsp_rdata_d[8*b +: 8] = {8{rsp_rdata_q[7]}};
                            end
                        end
                    end else begin
                        byte_d     = byte_q + BYTE_W'(1);
                        mem_addr_d = addr_q + ADDR_W'(byte_q) + ADDR_W'(1);
                        if (write_q) begin
                            mem_wdata_d    = wdata_q[8*(int'(byte_q) + 1) +: 8];
                            mem_do_write_d = 1'b1;
                        end
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any access in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            byte_q         <= '0;
            cyc_q          <= '0;
            addr_q         <= '0;
            len_q          <= '0;
            write_q        <= 1'b0;
            sext_q         <= 1'b0;
            wdata_q        <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_do_write_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_q         <= byte_d;
            cyc_q          <= cyc_d;
            addr_q         <= addr_d;
            len_q          <= len_d;
            write_q        <= write_d;
            sext_q         <= sext_d;
            wdata_q        <= wdata_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_do_write_q <= mem_do_write_d;
        end
    end

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Directed bench for cpu_bus_sequencer (MAX_BYTES=2, CPA=4), plus two extra
// instances with READ_LATENCY=2 and 3 sharing the request inputs.
module tb_cpu_bus_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic        req_sext = 1'b0;
    logic [15:0] req_addr = '0;
    logic [1:0]  req_len = '0;
    logic [15:0] req_wdata = '0;

    logic        req_ready, busy, rsp_valid, mem_do_write;
    logic [15:0] rsp_rdata, mem_addr;
    logic [7:0]  mem_data_write, mem_data_read;

    logic        req_ready_2, busy_2, rsp_valid_2, mem_do_write_2;
    logic [15:0] rsp_rdata_2, mem_addr_2;
    logic [7:0]  mem_data_write_2, mem_data_read_2;
    logic        req_ready_3, busy_3, rsp_valid_3, mem_do_write_3;
    logic [15:0] rsp_rdata_3, mem_addr_3;
    logic [7:0]  mem_data_write_3, mem_data_read_3;

    logic [7:0]  mem [0:65535];
    logic        sweep_mode = 1'b0;
    int          clk_idx = 0;
    int          acc_base = 0;
    int          rel;

    int          tests = 0;
    int          fails = 0;
    int          lat;

    int          acc_q[$];
    logic [15:0] rsp_q[$];
    logic [15:0] stb_addr_q[$];
    logic [7:0]  stb_data_q[$];
    int          stb_rel_q[$];

    always #5 clk = ~clk;

    assign rel             = clk_idx - acc_base;
    assign mem_data_read   = sweep_mode ? ((rel == 1) ? 8'h41 : 8'h00) : mem[mem_addr];
    assign mem_data_read_2 = sweep_mode ? ((rel == 2) ? 8'h42 : 8'h00) : mem[mem_addr_2];
    assign mem_data_read_3 = sweep_mode ? ((rel == 3) ? 8'h43 : 8'h00) : mem[mem_addr_3];

    cpu_bus_sequencer #(.MAX_BYTES(2), .CYCLES_PER_ACCESS(4), .READ_LATENCY(1), .ADDR_W(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_sext(req_sext), .req_addr(req_addr), .req_len(req_len),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_data_write(mem_data_write), .mem_do_write(mem_do_write),
        .mem_data_read(mem_data_read)
    );

    cpu_bus_sequencer #(.MAX_BYTES(2), .CYCLES_PER_ACCESS(4), .READ_LATENCY(2), .ADDR_W(16)) dut_l2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_2),
        .req_write(req_write), .req_sext(req_sext), .req_addr(req_addr), .req_len(req_len),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid_2), .rsp_rdata(rsp_rdata_2), .busy(busy_2),
        .mem_addr(mem_addr_2), .mem_data_write(mem_data_write_2), .mem_do_write(mem_do_write_2),
        .mem_data_read(mem_data_read_2)
    );

    cpu_bus_sequencer #(.MAX_BYTES(2), .CYCLES_PER_ACCESS(4), .READ_LATENCY(3), .ADDR_W(16)) dut_l3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_3),
        .req_write(req_write), .req_sext(req_sext), .req_addr(req_addr), .req_len(req_len),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid_3), .rsp_rdata(rsp_rdata_3), .busy(busy_3),
        .mem_addr(mem_addr_3), .mem_data_write(mem_data_write_3), .mem_do_write(mem_do_write_3),
        .mem_data_read(mem_data_read_3)
    );

    // Edge monitor: clock index, accepts, write strobes and responses of the main instance.
    always @(posedge clk) begin
        clk_idx <= clk_idx + 1;
        if (req_valid && req_ready && !reset) begin
            acc_base <= clk_idx;
            acc_q.push_back(clk_idx);
        end
        if (mem_do_write) begin
            stb_addr_q.push_back(mem_addr);
            stb_data_q.push_back(mem_data_write);
            stb_rel_q.push_back(clk_idx - acc_base);
        end
        if (rsp_valid) rsp_q.push_back(rsp_rdata);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_q.delete();
        rsp_q.delete();
        stb_addr_q.delete();
        stb_data_q.delete();
        stb_rel_q.delete();
    endtask

    // Presents one request and returns in clock 1 after the accept edge.
    task automatic do_req(input logic w, input logic s, input logic [15:0] a,
                          input logic [1:0] n, input logic [15:0] wd);
        int g;
        g = 0;
        while (!req_ready && g < 50) begin
            tick();
            g++;
        end
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_write = w;
        req_sext  = s;
        req_addr  = a;
        req_len   = n;
        req_wdata = wd;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Steps from clock 'start' until rsp_valid is seen (bounded).
    task automatic wait_rsp(input int start, output int n);
        n = start;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        check("rsp_seen", {31'd0, rsp_valid}, 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, req_ready}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd1);
        check("reset_addr", {16'd0, mem_addr}, 32'h0);
        check("reset_rdata", {16'd0, rsp_rdata}, 32'h0);
        reset = 1'b0;
        tick();
        check("post_reset_ready", {31'd0, req_ready}, 32'd1);
        check("post_reset_wstb", {31'd0, mem_do_write}, 32'd0);
        check("post_reset_wdata", {24'd0, mem_data_write}, 32'h0);
        check("post_reset_valid", {31'd0, rsp_valid}, 32'd0);

        // 1-byte read, no sign extension
        mem[16'h0150] = 8'h9C;
        do_req(1'b0, 1'b0, 16'h0150, 2'd1, 16'h0);
        check("rd1_addr", {16'd0, mem_addr}, 32'h0150);
        check("rd1_busy", {31'd0, busy}, 32'd1);
        wait_rsp(1, lat);
        check("rd1_latency", lat, 32'd5);
        check("rd1_rdata", {16'd0, rsp_rdata}, 32'h009C);
        tick();
        check("rd1_pulse_end", {31'd0, rsp_valid}, 32'd0);
        check("rd1_rdata_hold", {16'd0, rsp_rdata}, 32'h009C);

        // sign extension, negative then positive byte
        do_req(1'b0, 1'b1, 16'h0150, 2'd1, 16'h0);
        wait_rsp(1, lat);
        check("sext_neg", {16'd0, rsp_rdata}, 32'hFF9C);
        mem[16'h0150] = 8'h7C;
        do_req(1'b0, 1'b1, 16'h0150, 2'd1, 16'h0);
        wait_rsp(1, lat);
        check("sext_pos", {16'd0, rsp_rdata}, 32'h007C);

        // 2-byte read across the address wrap
        mem[16'hFFFF] = 8'h34;
        mem[16'h0000] = 8'h12;
        do_req(1'b0, 1'b0, 16'hFFFF, 2'd2, 16'h0);
        check("wrap_addr0", {16'd0, mem_addr}, 32'hFFFF);
        repeat (3) tick();
        check("wrap_addr0_hold", {16'd0, mem_addr}, 32'hFFFF);
        tick();
        check("wrap_addr1", {16'd0, mem_addr}, 32'h0000);
        wait_rsp(5, lat);
        check("wrap_latency", lat, 32'd9);
        check("wrap_rdata", {16'd0, rsp_rdata}, 32'h1234);

        // 2-byte write
        tick();
        clear_logs();
        do_req(1'b1, 1'b0, 16'hC000, 2'd2, 16'hBEEF);
        check("wr_stb_first", {31'd0, mem_do_write}, 32'd1);
        check("wr_data_first", {24'd0, mem_data_write}, 32'hEF);
        tick();
        check("wr_stb_off", {31'd0, mem_do_write}, 32'd0);
        check("wr_data_hold", {24'd0, mem_data_write}, 32'hEF);
        wait_rsp(2, lat);
        check("wr_latency", lat, 32'd9);
        check("wr_rdata", {16'd0, rsp_rdata}, 32'h0);
        check("wr_addr_hold", {16'd0, mem_addr}, 32'hC001);
        check("wr_stb_count", stb_addr_q.size(), 32'd2);
        if (stb_addr_q.size() == 2) begin
            check("wr_stb0_addr", {16'd0, stb_addr_q[0]}, 32'hC000);
            check("wr_stb0_data", {24'd0, stb_data_q[0]}, 32'hEF);
            check("wr_stb0_clock", stb_rel_q[0], 32'd1);
            check("wr_stb1_addr", {16'd0, stb_addr_q[1]}, 32'hC001);
            check("wr_stb1_data", {24'd0, stb_data_q[1]}, 32'hBE);
            check("wr_stb1_clock", stb_rel_q[1], 32'd5);
        end

        // zero-length request: immediate completion, bus untouched
        tick();
        clear_logs();
        do_req(1'b1, 1'b0, 16'h3000, 2'd0, 16'h5555);
        wait_rsp(1, lat);
        check("len0_latency", lat, 32'd1);
        check("len0_rdata", {16'd0, rsp_rdata}, 32'h0);
        check("len0_addr_hold", {16'd0, mem_addr}, 32'hC001);
        tick();
        check("len0_no_stb", stb_addr_q.size(), 32'd0);

        // over-length request clamps to 2; sext ignored for len 2
        mem[16'h0200] = 8'h91;
        mem[16'h0201] = 8'h22;
        mem[16'h0202] = 8'h33;
        do_req(1'b0, 1'b1, 16'h0200, 2'd3, 16'h0);
        wait_rsp(1, lat);
        check("clamp_latency", lat, 32'd9);
        check("clamp_rdata", {16'd0, rsp_rdata}, 32'h2291);

        // reset in clock 2 of a 2-byte write
        tick();
        clear_logs();
        do_req(1'b1, 1'b0, 16'hC000, 2'd2, 16'hBEEF);
        tick();
        reset = 1'b1;
        tick();
        check("abort_wstb", {31'd0, mem_do_write}, 32'd0);
        check("abort_addr", {16'd0, mem_addr}, 32'h0);
        check("abort_wdata", {24'd0, mem_data_write}, 32'h0);
        check("abort_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_ready_in_reset", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        tick();
        check("abort_ready_after", {31'd0, req_ready}, 32'd1);
        repeat (12) tick();
        check("abort_stb_count", stb_addr_q.size(), 32'd1);
        check("abort_rsp_count", rsp_q.size(), 32'd0);

        // back-to-back reads with req_valid held; inputs changed while busy
        mem[16'h0150] = 8'h5A;
        mem[16'h0400] = 8'hA7;
        clear_logs();
        req_write = 1'b0;
        req_sext  = 1'b0;
        req_addr  = 16'h0150;
        req_len   = 2'd1;
        req_valid = 1'b1;
        tick();
        req_addr  = 16'h0400;
        req_sext  = 1'b1;
        repeat (10) tick();
        req_valid = 1'b0;
        repeat (3) tick();
        check("b2b_accepts", acc_q.size(), 32'd2);
        check("b2b_rsps", rsp_q.size(), 32'd2);
        if (acc_q.size() == 2 && rsp_q.size() == 2) begin
            check("b2b_spacing", acc_q[1] - acc_q[0], 32'd6);
            check("b2b_first", {16'd0, rsp_q[0]}, 32'h005A);
            check("b2b_second", {16'd0, rsp_q[1]}, 32'hFFA7);
        end

        // read-latency sweep: data only present on clock READ_LATENCY
        sweep_mode = 1'b1;
        do_req(1'b0, 1'b0, 16'h0777, 2'd1, 16'h0);
        wait_rsp(1, lat);
        check("sweep_l1", {16'd0, rsp_rdata}, 32'h0041);
        check("sweep_l2", {16'd0, rsp_rdata_2}, 32'h0042);
        check("sweep_l3", {16'd0, rsp_rdata_3}, 32'h0043);
        sweep_mode = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
